phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
Generates the processor's phase counter and per-phase enables. It replaces the free-running phase input and clock-gated strobes with a registered one-hot enable vector. It owns run/stop control from the front-panel exec button, single-step, and halt-at-instruction-boundary. It sits between the board buttons and the datapath registers, feeding phase and phase_en to every stage.

Parameters:
NUM_PHASES, 5, phases per instruction; legal range 2..8.
DEBOUNCE_CYCLES, 4, number of consecutive stable samples needed to accept a button level.
ICOUNT_W, 16, width of the retired-instruction counter.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low; clears all state.
exec_n  input  1  exec push button, active-low, asynchronous to clock.
step_n  input  1  single-step push button, active-low, asynchronous to clock.
halt  input  1  halt request from the datapath decode.
phase  output  3  current phase index, 0..NUM_PHASES-1.
phase_en  output  NUM_PHASES  one-hot enable: bit k is high when phase==k and a phase is executing.
running  output  1  high while an instruction is executing (RUN or STEP).
halted  output  1  high in the HALTED state.
instr_count  output  ICOUNT_W  count of completed instructions; wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, phase=0, phase_en=0, running=0, halted=0, instr_count=0.
  - Synchronizers and debouncers are cleared to the released level (1).
  - halt_req and stop_req are cleared.
  - Reset mid-instruction aborts immediately; no count increment.
- Button conditioning:
  - Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
  - A 1-to-0 transition of the debounced level produces a single-cycle pulse (exec_p or step_p).
  - Latency from a clean press to the pulse is 2+DEBOUNCE_CYCLES cycles. Holding a button gives exactly one pulse.
- States: IDLE, RUN, STEP, HALTED.
  - IDLE: phase=0, phase_en=0. exec_p moves to RUN; step_p moves to STEP.
  - RUN / STEP: running=1, phase_en=onehot(phase).
    - Each cycle, phase increments; after NUM_PHASES-1 it wraps to 0. The wrap edge is the instruction boundary.
    - At each boundary, instr_count increments (modulo 2^ICOUNT_W).
  - HALTED: halted=1, phase=0, phase_en=0. exec_p resumes RUN; step_p moves to STEP.
- The first executing cycle after entering RUN or STEP has phase=0. The state and phase registers update on the same edge.
- Boundary decisions, in priority order:
  1. halt_req: go to HALTED.
  2. Current state is STEP: go to IDLE.
  3. stop_req: go to IDLE.
  4. Otherwise: stay in RUN.
  - halt_req and stop_req are cleared at every boundary.
- halt_req: sticky. Set when halt=1 in any executing cycle, including the boundary cycle itself. An instruction always completes all phases.
- stop_req: set by exec_p while in RUN; takes effect at the boundary. exec_p while in STEP is ignored.
- step_p while in RUN or STEP is ignored.
- Simultaneous exec_p and step_p in IDLE or HALTED: exec_p wins and the state goes to RUN.
- Simultaneous halt and exec_p in RUN: both requests are set; halt wins at the boundary and goes to HALTED. The exec press is consumed.
- halt level in IDLE or HALTED is ignored.
- phase and phase_en are never X. phase_en is all-zero whenever running=0.

Optional Feature:
PHASE_SEQ_SINGLE_STEP_EN
- Defined: the step_n synchronizer, debouncer and STEP state exist as specified above.
- Undefined: step_n is unused and tied off internally, no STEP state is built, and step_p is constant 0. All other behaviour is identical.

Test Plan:
- Reset, then exec_n low for 10 cycles -> after 6 cycles state=RUN; phase sequence 0,1,2,3,4,0; phase_en sequence 00001,00010,...,10000; instr_count=1 after the first wrap.
- In RUN, pulse halt=1 for one cycle at phase=1 -> phases 2,3,4 still execute, then halted=1, phase=0, phase_en=0, instr_count incremented once.
- In RUN, press exec during phase=2 -> phases 3,4 complete, then IDLE with running=0; a second press restarts at phase=0.
- With PHASE_SEQ_SINGLE_STEP_EN defined, press step in IDLE -> exactly 5 enable cycles, instr_count +1, back to IDLE. Without the macro, the same stimulus leaves phase_en=0 throughout.
- Button bounce: exec_n toggling every cycle for 3 cycles, then stable low -> exactly one exec_p. Glitch of fewer than 4 cycles -> no pulse.
- Assert reset at phase=3 in RUN -> phase=0, phase_en=0, instr_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//   Generates the instruction phase counter and a registered one-hot phase
//   enable vector. Owns run/stop control from the exec button, single-step
//   from the step button, and halt at the instruction boundary.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   exec_n       in   exec push button, active-low, asynchronous
//   step_n       in   single-step push button, active-low, asynchronous
//   halt         in   halt request from datapath decode
//   phase        out  current phase index 0..NUM_PHASES-1
//   phase_en     out  one-hot phase enable, all-zero when not executing
//   running      out  high while an instruction executes (RUN or STEP)
//   halted       out  high in the HALTED state
//   instr_count  out  completed-instruction counter, wraps
//
// Build option:
//   PHASE_SEQ_SINGLE_STEP_EN  when defined, builds the step button path and
//                             the STEP state; otherwise step_n is ignored.
// -----------------------------------------------------------------------------

// Button conditioner: 2-FF synchronizer, debouncer, falling-edge pulse.
module phase_sequencer_btn #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive synchronized samples that disagree with the
    // accepted level; the level flips on the DEBOUNCE_CYCLES-th such sample.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Pulse is taken from the level about to fall, so the FSM acts on the
    // same edge that the debounced level changes.
    assign press_o = level_q & ~level_d;

    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_ni;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

module phase_sequencer #(
    parameter int unsigned NUM_PHASES      = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned ICOUNT_W        = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exec_n,
    input  logic                  step_n,
    input  logic                  halt,
    output logic [2:0]            phase,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic                  running,
    output logic                  halted,
    output logic [ICOUNT_W-1:0]   instr_count
);

    localparam logic [2:0]            LAST_PHASE = 3'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] FIRST_EN   = NUM_PHASES'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
`ifdef PHASE_SEQ_SINGLE_STEP_EN
        S_STEP   = 2'd2,
`endif
        S_HALTED = 2'd3
    } state_e;

    state_e                state_q;
    logic [2:0]            phase_q;
    logic [NUM_PHASES-1:0] phase_en_q;
    logic                  running_q;
    logic                  halted_q;
    logic [ICOUNT_W-1:0]   count_q;
    logic                  halt_req_q;
    logic                  stop_req_q;

    logic exec_p;
    logic in_run, in_step, at_boundary, halt_now, stop_now;

    phase_sequencer_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_exec_btn (
        .clock_i(clock),
        .rst_ni (reset),
        .btn_ni (exec_n),
        .press_o(exec_p)
    );

`ifdef PHASE_SEQ_SINGLE_STEP_EN
    logic step_p;

    phase_sequencer_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clock_i(clock),
        .rst_ni (reset),
        .btn_ni (step_n),
        .press_o(step_p)
    );
`else
    logic unused_step_n;
    assign unused_step_n = step_n;
`endif

    // Requests include the current cycle's inputs so a halt or exec press on
    // the boundary cycle itself is honoured at that boundary.
    always_comb begin
        in_run      = (state_q == S_RUN);
`ifdef PHASE_SEQ_SINGLE_STEP_EN
        in_step     = (state_q == S_STEP);
`else
        in_step     = 1'b0;
`endif
        at_boundary = (phase_q == LAST_PHASE);
        halt_now    = halt_req_q | halt;
        stop_now    = stop_req_q | (exec_p & in_run);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            phase_en_q <= '0;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
            halt_req_q <= 1'b0;
            stop_req_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    // exec wins over step when both arrive together.
                    if (exec_p) begin
                        state_q    <= S_RUN;
                        phase_q    <= '0;
                        phase_en_q <= FIRST_EN;
                        running_q  <= 1'b1;
                        halted_q   <= 1'b0;
                    end
`ifdef PHASE_SEQ_SINGLE_STEP_EN
                    else if (step_p) begin
                        state_q    <= S_STEP;
                        phase_q    <= '0;
                        phase_en_q <= FIRST_EN;
                        running_q  <= 1'b1;
                        halted_q   <= 1'b0;
                    end
`endif
                end
                default: begin
                    if (at_boundary) begin
                        count_q    <= count_q + ICOUNT_W'(1);
                        phase_q    <= '0;
                        halt_req_q <= 1'b0;
                        stop_req_q <= 1'b0;
                        if (halt_now) begin
                            state_q    <= S_HALTED;
                            phase_en_q <= '0;
                            running_q  <= 1'b0;
                            halted_q   <= 1'b1;
                        end else if (in_step || stop_now) begin
                            state_q    <= S_IDLE;
                            phase_en_q <= '0;
                            running_q  <= 1'b0;
                        end else begin
                            phase_en_q <= FIRST_EN;
                        end
                    end else begin
                        phase_q    <= phase_q + 3'd1;
                        phase_en_q <= phase_en_q << 1;
                        halt_req_q <= halt_now;
                        stop_req_q <= stop_now;
                    end
                end
            endcase
        end
    end

    assign phase       = phase_q;
    assign phase_en    = phase_en_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//   Self-checking bench for phase_sequencer: a directed vector table, a few
//   hand-written multi-cycle sequences and a randomized run, all compared
//   against a cycle-level reference model of the sequencer's rules.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

    localparam int NP = 5;
    localparam int DB = 4;
    localparam int IW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          exec_n;
    logic          step_n;
    logic          halt;
    logic [2:0]    phase;
    logic [NP-1:0] phase_en;
    logic          running;
    logic          halted;
    logic [IW-1:0] instr_count;

    always #5 clock = ~clock;

    phase_sequencer #(
        .NUM_PHASES     (NP),
        .DEBOUNCE_CYCLES(DB),
        .ICOUNT_W       (IW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .exec_n     (exec_n),
        .step_n     (step_n),
        .halt       (halt),
        .phase      (phase),
        .phase_en   (phase_en),
        .running    (running),
        .halted     (halted),
        .instr_count(instr_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALTED = 3;

`ifdef PHASE_SEQ_SINGLE_STEP_EN
    localparam bit STEP_BUILT = 1'b1;
`else
    localparam bit STEP_BUILT = 1'b0;
`endif

    int          m_state;
    int          m_phase;
    logic [15:0] m_count;
    bit          m_halt_req, m_stop_req;
    bit          m_edb, m_sdb;
    bit [4:0]    m_ehist, m_shist;   // [0] = raw level seen at the previous edge

    task automatic model_reset();
        m_state    = M_IDLE;
        m_phase    = 0;
        m_count    = '0;
        m_halt_req = 1'b0;
        m_stop_req = 1'b0;
        m_edb      = 1'b1;
        m_sdb      = 1'b1;
        m_ehist    = '1;
        m_shist    = '1;
    endtask

    // A raw level reaches the debouncer two edges after it is sampled; the
    // debounced level flips once the last DB synchronized samples all oppose it.
    task automatic debounce(inout bit db, inout bit [4:0] hist, input bit raw, output bit pulse);
        pulse = 1'b0;
        if (db && hist[4:1] == 4'b0000) begin
            pulse = 1'b1;
            db    = 1'b0;
        end else if (!db && hist[4:1] == 4'b1111) begin
            db = 1'b1;
        end
        hist = {hist[3:0], raw};
    endtask

    task automatic model_edge(input bit e_n, input bit s_n, input bit h);
        bit ep, sp, hr, sr;
        debounce(m_edb, m_ehist, e_n, ep);
        debounce(m_sdb, m_shist, s_n, sp);
        if (!STEP_BUILT) sp = 1'b0;
        if (m_state == M_IDLE || m_state == M_HALTED) begin
            if (ep) begin
                m_state = M_RUN;
                m_phase = 0;
            end else if (sp) begin
                m_state = M_STEP;
                m_phase = 0;
            end
        end else begin
            hr = m_halt_req || h;
            sr = m_stop_req || (ep && m_state == M_RUN);
            if (m_phase == NP - 1) begin
                m_count    = m_count + 16'd1;
                m_phase    = 0;
                m_halt_req = 1'b0;
                m_stop_req = 1'b0;
                if (hr)                     m_state = M_HALTED;
                else if (m_state == M_STEP) m_state = M_IDLE;
                else if (sr)                m_state = M_IDLE;
            end else begin
                m_phase    = m_phase + 1;
                m_halt_req = hr;
                m_stop_req = sr;
            end
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [4:0] en;
        logic       run;
        run = (m_state == M_RUN) || (m_state == M_STEP);
        en  = run ? 5'(1 << m_phase) : 5'd0;
        return 32'({3'(m_phase), en, run, (m_state == M_HALTED), m_count});
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({phase, phase_en, running, halted, instr_count});
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a falling edge: drive, let one rising edge pass, compare.
    task automatic cycle(input bit e_n, input bit s_n, input bit h, input string tag);
        exec_n = e_n;
        step_n = s_n;
        halt   = h;
        @(posedge clock);
        model_edge(e_n, s_n, h);
        @(negedge clock);
        check(tag, dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        exec_n = 1'b1;
        step_n = 1'b1;
        halt   = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         e_n;
        bit         s_n;
        bit         h;
        logic [2:0] ph;
        logic [4:0] en;
        bit         run;
        bit         hlt;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int   en_cycles;
        bit   found;
        bit   e_lvl, s_lvl;
        int   e_hold, s_hold;

        // press exec for 10 cycles from IDLE: RUN begins on the 6th edge
        for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'd0, 5'b00001, 1'b1, 1'b0, 16'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 3'd1, 5'b00010, 1'b1, 1'b0, 16'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 3'd2, 5'b00100, 1'b1, 1'b0, 16'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'd3, 5'b01000, 1'b1, 1'b0, 16'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'd4, 5'b10000, 1'b1, 1'b0, 16'd0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 3'd0, 5'b00001, 1'b1, 1'b0, 16'd1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 3'd1, 5'b00010, 1'b1, 1'b0, 16'd1};

        reset  = 1'b0;
        exec_n = 1'b1;
        step_n = 1'b1;
        halt   = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_state", dut_vec(), 32'd0);
        reset = 1'b1;
        model_reset();

        // directed table
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].e_n, tbl[i].s_n, tbl[i].h, "table_model");
            check($sformatf("table[%0d]", i), dut_vec(),
                  32'({tbl[i].ph, tbl[i].en, tbl[i].run, tbl[i].hlt, tbl[i].cnt}));
        end

        // halt pulse at phase 1: phases 2,3,4 still execute, then HALTED
        cycle(1'b1, 1'b1, 1'b1, "halt_pulse");
        check("halt_phase2", 32'(phase), 32'd2);
        cycle(1'b1, 1'b1, 1'b0, "halt_run");
        cycle(1'b1, 1'b1, 1'b0, "halt_run");
        cycle(1'b1, 1'b1, 1'b0, "halt_boundary");
        check("halted_state", dut_vec(), 32'({3'd0, 5'd0, 1'b0, 1'b1, 16'd2}));

        // resume from HALTED, then an exec press in RUN stops at the boundary
        for (int i = 0; i < 8; i++)  cycle(1'b0, 1'b1, 1'b0, "resume_press");
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, "resume_run");
        check("resume_running", 32'({running, halted}), 32'b10);
        for (int i = 0; i < 8; i++)  cycle(1'b0, 1'b1, 1'b0, "stop_press");
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 1'b0, "stop_drain");
        check("stop_idle", 32'({running, halted, phase_en}), 32'd0);
        for (int i = 0; i < 8; i++)  cycle(1'b0, 1'b1, 1'b0, "restart_press");
        check("restart_phase", 32'({running, phase}), 32'({1'b1, 3'd2}));

        // single step from IDLE
        do_reset();
        en_cycles = 0;
        for (int i = 0; i < 25; i++) begin
            cycle(1'b1, (i < 8) ? 1'b0 : 1'b1, 1'b0, "step");
            if (phase_en != '0) en_cycles++;
        end
        check("step_en_cycles", 32'(en_cycles), STEP_BUILT ? 32'd5 : 32'd0);
        check("step_count", 32'(instr_count), STEP_BUILT ? 32'd1 : 32'd0);
        check("step_idle", 32'({running, halted}), 32'd0);

        // bouncing exec then held low: exactly one pulse, so RUN persists
        cycle(1'b0, 1'b1, 1'b0, "bounce");
        cycle(1'b1, 1'b1, 1'b0, "bounce");
        cycle(1'b0, 1'b1, 1'b0, "bounce");
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, "bounce_hold");
        check("bounce_one_pulse", 32'(running), 32'd1);

        // short glitch: no pulse
        do_reset();
        for (int i = 0; i < 3; i++)  cycle(1'b0, 1'b1, 1'b0, "glitch");
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, "glitch_idle");
        check("glitch_no_pulse", 32'({running, phase_en}), 32'd0);

        // randomized buttons and halt
        e_lvl  = 1'b1;
        s_lvl  = 1'b1;
        e_hold = 10;
        s_hold = 10;
        for (int i = 0; i < 3000; i++) begin
            if (e_hold == 0) begin
                e_lvl  = ~e_lvl;
                e_hold = $urandom_range(1, 25);
            end
            if (s_hold == 0) begin
                s_lvl  = ~s_lvl;
                s_hold = $urandom_range(1, 30);
            end
            e_hold--;
            s_hold--;
            cycle(e_lvl, s_lvl, ($urandom_range(0, 15) == 0), "random");
        end

        // asynchronous reset at phase 3 while RUN
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (running && phase == 3'd3 && instr_count != '0) found = 1'b1;
            else cycle((i < 8) ? 1'b0 : 1'b1, 1'b1, 1'b0, "seek_phase3");
        end
        check("seek_phase3", 32'(found), 32'd1);
        #2 reset = 1'b0;
        #1 check("async_reset", dut_vec(), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        cycle(1'b1, 1'b1, 1'b0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
